// File: rtl/pc_gen.sv
// pc_gen: program counter for the rv32i fetch stage.
// Produces the fetch address and a valid/ready request towards instruction
// memory. The PC steps forward after each accepted fetch and can be redirected
// by a relative branch, an absolute jump, a trap entry or an mret. A redirect
// target that is not aligned to the instruction step becomes a trap to
// i_trap_vec. That case raises a one-cycle o_misaligned pulse and records the
// offending target in o_bad_addr.

`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_0000
`endif

`ifndef PC_STEP
`define PC_STEP 4
`endif

module pc_gen #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR  = `BOOT_ADDR,
   parameter int unsigned     PC_STEP    = `PC_STEP,
   parameter int unsigned     ALIGN_BITS = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic            i_redirect_sel,
   input  logic [XLEN-1:0] i_pc_in,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic            i_mret,
   input  logic            i_fetch_ready,
   output logic            o_fetch_valid,
   output logic [XLEN-1:0] o_pc_out,
   output logic [XLEN-1:0] o_pc_plus_step,
   output logic [XLEN-1:0] o_epc,
   output logic            o_misaligned,
   output logic [XLEN-1:0] o_bad_addr
);

   // Sequential increment and the mask of target bits that must be zero.
   // The mask form also covers ALIGN_BITS == 0 without a zero-width slice.
   localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   // BOOT is the single cycle after reset with no fetch request. RUN issues
   // a request. WAIT means that request is being held under back-pressure.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_epc;
   logic [XLEN-1:0] r_bad_addr;
   logic            r_misaligned;

   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_epc_nxt;
   logic [XLEN-1:0] w_bad_addr_nxt;
   logic            w_misaligned_nxt;

   logic [XLEN-1:0] w_pc_plus_step;
   logic [XLEN-1:0] w_rel_target;
   logic [XLEN-1:0] w_abs_target;
   logic [XLEN-1:0] w_target;
   logic            w_target_bad;
   logic            w_active;

   // Redirect targets. All sums wrap silently modulo 2^XLEN, and a negative
   // i_pc_in works as a backward branch through two's-complement wrap.
   assign w_pc_plus_step = r_pc + STEP;
   assign w_rel_target   = r_pc + i_pc_in;
   assign w_abs_target   = {i_pc_in[XLEN-1:1], 1'b0};
   assign w_target       = i_redirect_sel ? w_abs_target : w_rel_target;
   assign w_target_bad   = |(w_target & ALIGN_MASK);

   // The fetch request is valid in every state except BOOT.
   assign w_active = (r_state != ST_BOOT);

   // Next-state and next-datapath decode. The priority is trap, stall, mret,
   // redirect, handshake, hold. Any event takes the FSM back to RUN, because
   // the new PC is a fresh request and the pending fetch is dropped.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch can be inferred.
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_epc_nxt        = r_epc;
      w_bad_addr_nxt   = r_bad_addr;
      w_misaligned_nxt = 1'b0;

      unique case (r_state)
         ST_BOOT: begin
            // Events and handshakes are ignored while BOOT lasts.
            w_state_nxt = ST_RUN;
         end

         ST_RUN, ST_WAIT: begin
            if (i_trap) begin
               // Trap entry overrides stall and drops a simultaneous mret.
               w_pc_nxt    = i_trap_vec;
               w_epc_nxt   = r_pc;
               w_state_nxt = ST_RUN;
            end else if (i_stall) begin
               // Hold everything. The requester re-asserts redirect or mret.
               w_state_nxt = r_state;
            end else if (i_mret) begin
               w_pc_nxt    = r_epc;
               w_state_nxt = ST_RUN;
            end else if (i_redirect_valid) begin
               w_state_nxt = ST_RUN;
               if (w_target_bad) begin
                  // A misaligned target is taken as a trap to the handler.
                  w_misaligned_nxt = 1'b1;
                  w_bad_addr_nxt   = w_target;
                  w_epc_nxt        = r_pc;
                  w_pc_nxt         = i_trap_vec;
               end else begin
                  w_pc_nxt = w_target;
               end
            end else if (i_fetch_ready) begin
               // Fetch accepted: advance and issue the next request.
               w_pc_nxt    = w_pc_plus_step;
               w_state_nxt = ST_RUN;
            end else begin
               // Back-pressure: keep the request stable until it is accepted.
               w_state_nxt = ST_WAIT;
            end
         end

         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register updates from values taken before the edge, whatever order
      // the blocks run in.
      if (!i_rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC, exception PC, misalignment pulse and bad address registers.
   always_ff @(posedge i_clk) begin
      // NOTE: every register here has a defined reset value. Reset forces
      // BOOT and so drops any fetch that was waiting for a handshake.
      if (!i_rst) begin
         r_pc         <= BOOT_ADDR;
         r_epc        <= '0;
         r_bad_addr   <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_epc        <= w_epc_nxt;
         r_bad_addr   <= w_bad_addr_nxt;
         r_misaligned <= w_misaligned_nxt;
      end
   end

   assign o_fetch_valid  = w_active;
   assign o_pc_out       = r_pc;
   assign o_pc_plus_step = w_pc_plus_step;
   assign o_epc          = r_epc;
   assign o_misaligned   = r_misaligned;
   assign o_bad_addr     = r_bad_addr;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
// Each step drives the inputs and pushes the expected post-edge state onto a
// scoreboard. After the clock edge that entry is popped and compared with the
// DUT outputs.

module tb_pc_gen;

   localparam int XLEN = 32;

   typedef struct {
      string           tag;
      logic [XLEN-1:0] pc;
      logic            fv;
      logic            mis;
      bit              chk_ex;
      logic [XLEN-1:0] epc;
      logic [XLEN-1:0] bad;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            stall;
   logic            redirect_valid;
   logic            redirect_sel;
   logic [XLEN-1:0] pc_in;
   logic            trap;
   logic [XLEN-1:0] trap_vec;
   logic            mret;
   logic            fetch_ready;
   logic            fetch_valid;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus_step;
   logic [XLEN-1:0] epc;
   logic            misaligned;
   logic [XLEN-1:0] bad_addr;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   pc_gen #(
      .XLEN      (XLEN),
      .BOOT_ADDR (32'h0000_0000),
      .PC_STEP   (4),
      .ALIGN_BITS(2)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_stall         (stall),
      .i_redirect_valid(redirect_valid),
      .i_redirect_sel  (redirect_sel),
      .i_pc_in         (pc_in),
      .i_trap          (trap),
      .i_trap_vec      (trap_vec),
      .i_mret          (mret),
      .i_fetch_ready   (fetch_ready),
      .o_fetch_valid   (fetch_valid),
      .o_pc_out        (pc_out),
      .o_pc_plus_step  (pc_plus_step),
      .o_epc           (epc),
      .o_misaligned    (misaligned),
      .o_bad_addr      (bad_addr)
   );

   // Free-running core clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach the summary line");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Queue the expected result, let one edge pass, then compare at #1.
   task automatic tick(input string tag, input logic [XLEN-1:0] e_pc, input logic e_fv,
                       input logic e_mis, input bit e_chk, input logic [XLEN-1:0] e_epc,
                       input logic [XLEN-1:0] e_bad);
      exp_t e;
      exp_t got;
      e.tag = tag; e.pc = e_pc; e.fv = e_fv; e.mis = e_mis;
      e.chk_ex = e_chk; e.epc = e_epc; e.bad = e_bad;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         got = exp_q.pop_front();
         check({got.tag, ".pc"},   pc_out,                    got.pc);
         check({got.tag, ".fv"},   {{(XLEN-1){1'b0}}, fetch_valid}, {{(XLEN-1){1'b0}}, got.fv});
         check({got.tag, ".mis"},  {{(XLEN-1){1'b0}}, misaligned},  {{(XLEN-1){1'b0}}, got.mis});
         check({got.tag, ".pcps"}, pc_plus_step,              got.pc + 32'd4);
         if (got.chk_ex) begin
            check({got.tag, ".epc"}, epc,      got.epc);
            check({got.tag, ".bad"}, bad_addr, got.bad);
         end
      end
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
      pc_in = '0; trap = 1'b0; trap_vec = 32'h100; mret = 1'b0; fetch_ready = 1'b1;

      // Reset for two edges: BOOT state, no request.
      tick("rst0", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick("rst1", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

      // First edge out of reset leaves BOOT. A redirect asserted here is ignored.
      rst = 1'b1; redirect_valid = 1'b1; redirect_sel = 1'b1; pc_in = 32'h40;
      tick("boot", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      redirect_valid = 1'b0;
      tick("seq4", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick("seq8", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Back-pressure holds the request stable.
      fetch_ready = 1'b0;
      tick("bp1", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick("bp2", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick("bp3", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch_ready = 1'b1;
      tick("bp_rel", 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Relative and absolute redirects.
      redirect_valid = 1'b1; redirect_sel = 1'b1; pc_in = 32'h4;
      tick("jmp4", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      redirect_sel = 1'b0; pc_in = 32'h10;
      tick("rel_fwd", 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      pc_in = 32'hFFFF_FFF8;
      tick("rel_back", 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      redirect_sel = 1'b1; pc_in = 32'h41;
      tick("abs_bit0", 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Misaligned absolute target traps. mret then returns to the saved PC.
      pc_in = 32'h20;
      tick("jmp20", 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      pc_in = 32'h32;
      tick("mis_abs", 32'h100, 1'b1, 1'b1, 1'b1, 32'h20, 32'h32);
      redirect_valid = 1'b0; mret = 1'b1;
      tick("mret", 32'h20, 1'b1, 1'b0, 1'b1, 32'h20, 32'h32);
      mret = 1'b0;

      // Stall blocks a redirect, but a trap is still taken.
      stall = 1'b1; redirect_valid = 1'b1; redirect_sel = 1'b1; pc_in = 32'h80;
      tick("stall_redir", 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      redirect_valid = 1'b0; trap = 1'b1; trap_vec = 32'h200;
      tick("stall_trap", 32'h200, 1'b1, 1'b0, 1'b1, 32'h20, 32'h32);
      stall = 1'b0; trap_vec = 32'h300; mret = 1'b1;
      tick("trap_mret", 32'h300, 1'b1, 1'b0, 1'b1, 32'h200, 32'h32);
      trap = 1'b0; mret = 1'b0;

      // Misaligned relative target.
      trap_vec = 32'h100; redirect_valid = 1'b1; redirect_sel = 1'b0; pc_in = 32'h2;
      tick("mis_rel", 32'h100, 1'b1, 1'b1, 1'b1, 32'h300, 32'h302);
      redirect_valid = 1'b0;
      tick("mis_drop", 32'h104, 1'b1, 1'b0, 1'b1, 32'h300, 32'h302);

      // Wrap-around at the top of the address space.
      redirect_valid = 1'b1; redirect_sel = 1'b1; pc_in = 32'hFFFF_FFFC;
      tick("jmp_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      redirect_valid = 1'b0;
      tick("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick("post_wrap", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Enter WAIT, then reset mid-handshake.
      fetch_ready = 1'b0;
      tick("wait1", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick("wait2", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      tick("rst_mid", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      rst = 1'b1; fetch_ready = 1'b1;
      tick("reboot", 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
      tick("reseq", 32'h4, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
